// File: rtl/id_stage_pkg.sv
`default_nettype none
// =============================================================================
//  Module      : id_stage_pkg
//  Description : RV32I opcodes, op-class codes and packed decode entry type
//                shared by the decode stage and its output buffer.
//  Revision    : 1.0 - initial release
// =============================================================================
package id_stage_pkg;

    localparam logic [6:0] c_OPC_LUI      = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL      = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR     = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE    = 7'b0100011;
    localparam logic [6:0] c_OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OPC_OP       = 7'b0110011;
    localparam logic [6:0] c_OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] c_OPC_SYSTEM   = 7'b1110011;

    localparam logic [3:0] c_CLS_ALU_R  = 4'd0;
    localparam logic [3:0] c_CLS_ALU_I  = 4'd1;
    localparam logic [3:0] c_CLS_LOAD   = 4'd2;
    localparam logic [3:0] c_CLS_STORE  = 4'd3;
    localparam logic [3:0] c_CLS_BRANCH = 4'd4;
    localparam logic [3:0] c_CLS_LUI    = 4'd5;
    localparam logic [3:0] c_CLS_AUIPC  = 4'd6;
    localparam logic [3:0] c_CLS_JAL    = 4'd7;
    localparam logic [3:0] c_CLS_JALR   = 4'd8;
    localparam logic [3:0] c_CLS_FENCE  = 4'd9;
    localparam logic [3:0] c_CLS_ECALL  = 4'd10;
    localparam logic [3:0] c_CLS_EBREAK = 4'd11;
    localparam logic [3:0] c_CLS_CSR    = 4'd12;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] imm;
        logic [3:0]  op_class;
        logic [2:0]  funct3;
        logic        alt;
        logic        illegal;
        logic [11:0] csr_addr;
    } dec_t;

    localparam int c_DEC_W = $bits(dec_t);

endpackage
`default_nettype wire

// File: rtl/id_fifo.sv
`default_nettype none
// =============================================================================
//  Module      : id_fifo
//  Description : Small synchronous FIFO with flush and occupancy count; the
//                head word reads as zero while empty.
//  Revision    : 1.0 - initial release
// =============================================================================
module id_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_wr_en,
    input  logic [WIDTH-1:0]             i_wr_data,
    input  logic                         i_rd_en,
    output logic [WIDTH-1:0]             o_rd_data,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push = i_wr_en && (r_count != c_FULL_CNT) && !i_flush;
    assign w_pop  = i_rd_en && (r_count != '0) && !i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero whenever empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// =============================================================================
//  Module      : id_stage
//  Description : Registered RV32I decode stage feeding a valid/ready output
//                FIFO. Define ID_ZICSR_EN to decode Zicsr instructions.
//  Revision    : 1.0 - initial release
// =============================================================================
module id_stage
    import id_stage_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_inst,
    input  logic [ADDR_W-1:0] i_inst_addr,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [ADDR_W-1:0] o_inst_addr,
    output logic [4:0]        o_rs1_addr,
    output logic [4:0]        o_rs2_addr,
    output logic [4:0]        o_rd_addr,
    output logic              o_rd_we,
    output logic [31:0]       o_imm,
    output logic [3:0]        o_op_class,
    output logic [2:0]        o_funct3,
    output logic              o_alt,
    output logic              o_illegal,
    output logic [11:0]       o_csr_addr
);

    localparam int c_ENTRY_W = ADDR_W + c_DEC_W;
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(FIFO_DEPTH);

    logic [6:0]  w_opc;
    logic [4:0]  w_rd;
    logic [2:0]  w_f3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    dec_t        w_dec;
    logic        w_ill;

    assign w_opc   = i_inst[6:0];
    assign w_rd    = i_inst[11:7];
    assign w_f3    = i_inst[14:12];
    assign w_rs1   = i_inst[19:15];
    assign w_rs2   = i_inst[24:20];
    assign w_f7    = i_inst[31:25];
    assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_u = {i_inst[31:12], 12'b0};
    assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    always_comb begin
        w_dec        = '0;
        w_ill        = 1'b0;
        w_dec.funct3 = w_f3;
        case (w_opc)
            c_OPC_LUI: begin
                w_dec.op_class = c_CLS_LUI;
                w_dec.rd       = w_rd;
                w_dec.rd_we    = 1'b1;
                w_dec.imm      = w_imm_u;
            end
            c_OPC_AUIPC: begin
                w_dec.op_class = c_CLS_AUIPC;
                w_dec.rd       = w_rd;
                w_dec.rd_we    = 1'b1;
                w_dec.imm      = w_imm_u;
            end
            c_OPC_JAL: begin
                w_dec.op_class = c_CLS_JAL;
                w_dec.rd       = w_rd;
                w_dec.rd_we    = 1'b1;
                w_dec.imm      = w_imm_j;
            end
            c_OPC_JALR: begin
                w_dec.op_class = c_CLS_JALR;
                w_dec.rs1      = w_rs1;
                w_dec.rd       = w_rd;
                w_dec.rd_we    = 1'b1;
                w_dec.imm      = w_imm_i;
            end
            c_OPC_BRANCH: begin
                w_dec.op_class = c_CLS_BRANCH;
                w_dec.rs1      = w_rs1;
                w_dec.rs2      = w_rs2;
                w_dec.imm      = w_imm_b;
                w_ill          = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            c_OPC_LOAD: begin
                w_dec.op_class = c_CLS_LOAD;
                w_dec.rs1      = w_rs1;
                w_dec.rd       = w_rd;
                w_dec.rd_we    = 1'b1;
                w_dec.imm      = w_imm_i;
                w_ill          = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            c_OPC_STORE: begin
                w_dec.op_class = c_CLS_STORE;
                w_dec.rs1      = w_rs1;
                w_dec.rs2      = w_rs2;
                w_dec.imm      = w_imm_s;
                w_ill          = w_f3[2] || (w_f3 == 3'b011);
            end
            c_OPC_OP_IMM: begin
                w_dec.op_class = c_CLS_ALU_I;
                w_dec.rs1      = w_rs1;
                w_dec.rd       = w_rd;
                w_dec.rd_we    = 1'b1;
                w_dec.imm      = w_imm_i;
                // Shifts carry shamt in the rs2 field and funct7 in imm[11:5].
                if (w_f3 == 3'b001) begin
                    w_dec.rs2 = w_rs2;
                    w_ill     = (w_f7 != 7'h00);
                end else if (w_f3 == 3'b101) begin
                    w_dec.rs2 = w_rs2;
                    w_dec.alt = w_f7[5];
                    w_ill     = (w_f7 != 7'h00) && (w_f7 != 7'h20);
                end
            end
            c_OPC_OP: begin
                w_dec.op_class = c_CLS_ALU_R;
                w_dec.rs1      = w_rs1;
                w_dec.rs2      = w_rs2;
                w_dec.rd       = w_rd;
                w_dec.rd_we    = 1'b1;
                w_dec.alt      = w_f7[5];
                w_ill          = !((w_f7 == 7'h00) ||
                                   ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
            end
            c_OPC_MISC_MEM: begin
                w_dec.op_class = c_CLS_FENCE;
            end
            c_OPC_SYSTEM: begin
                if (w_f3 == 3'b000) begin
                    if (i_inst[31:7] == 25'h0000000) begin
                        w_dec.op_class = c_CLS_ECALL;
                    end else if (i_inst[31:7] == 25'h0002000) begin
                        w_dec.op_class = c_CLS_EBREAK;
                    end else begin
                        w_ill = 1'b1;
                    end
                end else begin
`ifdef ID_ZICSR_EN
                    if (w_f3 == 3'b100) begin
                        w_ill = 1'b1;
                    end else begin
                        w_dec.op_class = c_CLS_CSR;
                        w_dec.csr_addr = i_inst[31:20];
                        w_dec.rd       = w_rd;
                        w_dec.rd_we    = 1'b1;
                        if (w_f3[2]) begin
                            w_dec.imm = {27'b0, w_rs1};
                        end else begin
                            w_dec.rs1 = w_rs1;
                        end
                    end
`else
                    w_ill = 1'b1;
`endif
                end
            end
            default: w_ill = 1'b1;
        endcase

        w_dec.rd_we = w_dec.rd_we && (w_dec.rd != 5'd0);

        // Illegal entries keep only funct3 so ex can still identify the trap.
        if (w_ill) begin
            w_dec         = '0;
            w_dec.funct3  = w_f3;
            w_dec.illegal = 1'b1;
        end
    end

    logic                 r_init_done;
    logic                 w_empty;
    logic [c_CNT_W-1:0]   w_count;
    logic                 w_push;
    logic                 w_pop;
    logic [c_ENTRY_W-1:0] w_rd_data;
    dec_t                 w_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= 1'b1;
        end
    end

    assign o_ready = r_init_done && (w_count != c_FULL_CNT);
    assign o_valid = !w_empty;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    id_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (i_flush),
        .i_wr_en   (w_push),
        .i_wr_data ({i_inst_addr, w_dec}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    assign {o_inst_addr, w_head} = w_rd_data;
    assign o_rs1_addr = w_head.rs1;
    assign o_rs2_addr = w_head.rs2;
    assign o_rd_addr  = w_head.rd;
    assign o_rd_we    = w_head.rd_we;
    assign o_imm      = w_head.imm;
    assign o_op_class = w_head.op_class;
    assign o_funct3   = w_head.funct3;
    assign o_alt      = w_head.alt;
    assign o_illegal  = w_head.illegal;
    assign o_csr_addr = w_head.csr_addr;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// =============================================================================
//  Module      : tb_id_stage
//  Description : Scoreboard bench for id_stage (directed decode, back-pressure,
//                flush, reset and random traffic).
//  Revision    : 1.0 - initial release
// =============================================================================
module tb_id_stage;

    localparam int DEPTH = 2;
    localparam int NTBL  = 13;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_inst = '0;
    logic [31:0] i_inst_addr = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_inst_addr;
    logic [4:0]  o_rs1_addr;
    logic [4:0]  o_rs2_addr;
    logic [4:0]  o_rd_addr;
    logic        o_rd_we;
    logic [31:0] o_imm;
    logic [3:0]  o_op_class;
    logic [2:0]  o_funct3;
    logic        o_alt;
    logic        o_illegal;
    logic [11:0] o_csr_addr;

    always #5 clk = ~clk;

    id_stage #(
        .ADDR_W     (32),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (i_flush),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_inst      (i_inst),
        .i_inst_addr (i_inst_addr),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_inst_addr (o_inst_addr),
        .o_rs1_addr  (o_rs1_addr),
        .o_rs2_addr  (o_rs2_addr),
        .o_rd_addr   (o_rd_addr),
        .o_rd_we     (o_rd_we),
        .o_imm       (o_imm),
        .o_op_class  (o_op_class),
        .o_funct3    (o_funct3),
        .o_alt       (o_alt),
        .o_illegal   (o_illegal),
        .o_csr_addr  (o_csr_addr)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] imm;
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        alt;
        logic        ill;
        logic [11:0] csr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] tbl_inst [NTBL];
    exp_t        tbl_exp  [NTBL];

    function automatic exp_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic we, input logic [31:0] imm, input logic [3:0] cls,
                                input logic [2:0] f3, input logic alt, input logic ill,
                                input logic [11:0] csr);
        exp_t e;
        e = '{addr: 32'h0, rs1: rs1, rs2: rs2, rd: rd, we: we, imm: imm, cls: cls,
              f3: f3, alt: alt, ill: ill, csr: csr};
        return e;
    endfunction

    function automatic exp_t obs();
        exp_t e;
        e = '{addr: o_inst_addr, rs1: o_rs1_addr, rs2: o_rs2_addr, rd: o_rd_addr, we: o_rd_we,
              imm: o_imm, cls: o_op_class, f3: o_funct3, alt: o_alt, ill: o_illegal,
              csr: o_csr_addr};
        return e;
    endfunction

    // Class codes: 0 ALU_R 1 ALU_I 2 LOAD 3 STORE 4 BRANCH 5 LUI 7 JAL 11 EBREAK 12 CSR
    task automatic init_table();
        tbl_inst[0]  = 32'h00500093; tbl_exp[0]  = mk(0, 0, 1, 1, 32'd5,        1, 0, 0, 0, 0);
        tbl_inst[1]  = 32'hFE208EE3; tbl_exp[1]  = mk(1, 2, 0, 0, 32'hFFFFFFFC, 4, 0, 0, 0, 0);
        tbl_inst[2]  = 32'h0080006F; tbl_exp[2]  = mk(0, 0, 0, 0, 32'd8,        7, 0, 0, 0, 0);
        tbl_inst[3]  = 32'h40001093; tbl_exp[3]  = mk(0, 0, 0, 0, 32'd0,        0, 1, 0, 1, 0);
        tbl_inst[4]  = 32'h4000D093; tbl_exp[4]  = mk(1, 0, 1, 1, 32'h400,      1, 5, 1, 0, 0);
        tbl_inst[5]  = 32'h0000007F; tbl_exp[5]  = mk(0, 0, 0, 0, 32'd0,        0, 0, 0, 1, 0);
`ifdef ID_ZICSR_EN
        tbl_inst[6]  = 32'h30011073; tbl_exp[6]  = mk(2, 0, 0, 0, 32'd0,       12, 1, 0, 0, 12'h300);
`else
        tbl_inst[6]  = 32'h30011073; tbl_exp[6]  = mk(0, 0, 0, 0, 32'd0,        0, 1, 0, 1, 0);
`endif
        tbl_inst[7]  = 32'h402081B3; tbl_exp[7]  = mk(1, 2, 3, 1, 32'd0,        0, 0, 1, 0, 0);
        tbl_inst[8]  = 32'h0020A223; tbl_exp[8]  = mk(1, 2, 0, 0, 32'd4,        3, 2, 0, 0, 0);
        tbl_inst[9]  = 32'h00100073; tbl_exp[9]  = mk(0, 0, 0, 0, 32'd0,       11, 0, 0, 0, 0);
        tbl_inst[10] = 32'h123452B7; tbl_exp[10] = mk(0, 0, 5, 1, 32'h12345000, 5, 5, 0, 0, 0);
        tbl_inst[11] = 32'hFF80A303; tbl_exp[11] = mk(1, 0, 6, 1, 32'hFFFFFFF8, 2, 2, 0, 0, 0);
        tbl_inst[12] = 32'h00003303; tbl_exp[12] = mk(0, 0, 0, 0, 32'd0,        0, 3, 0, 1, 0);
    endtask

    // Drives one cycle of inputs and advances the scoreboard for the coming edge.
    task automatic drive(input logic v, input int idx, input logic [31:0] addr,
                         input logic rdy, input logic fl);
        int   n;
        exp_t e;
        n       = sb.size();
        e       = tbl_exp[idx];
        e.addr  = addr;
        i_valid = v;
        i_inst  = tbl_inst[idx];
        i_inst_addr = addr;
        i_ready = rdy;
        i_flush = fl;
        if (fl) begin
            sb.delete();
        end else begin
            if (rdy && n > 0) sb.delete(0);
            if (v && n < DEPTH) sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        checks++;
        if (o_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", o_ready); end
        checks++;
        if (obs() !== '0) begin failures++; $display("FAIL reset_head got=%h exp=0", obs()); end
        rst = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (o_ready !== 1'b0) begin failures++; $display("FAIL ready_early got=%b exp=0", o_ready); end
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b exp=1", o_ready); end
    endtask

    task automatic test_addi();
        drive(1, 0, 32'h100, 1, 0);
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%b exp=1", o_valid); end
        checks++;
        if (obs() !== sb[0]) begin failures++; $display("FAIL addi_head got=%h exp=%h", obs(), sb[0]); end
        drive(0, 0, 32'h0, 1, 0);
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL addi_drain got=%b exp=0", o_valid); end
    endtask

    task automatic test_backpressure();
        exp_t e;
        drive(1, 0, 32'hA00, 0, 0);
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", o_ready); end
        drive(1, 7, 32'hB00, 0, 0);
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", o_ready); end
        drive(1, 8, 32'hC00, 0, 0);
        @(negedge clk);
        checks++;
        if (obs() !== sb[0] || sb.size() != 2) begin
            failures++; $display("FAIL bp_hold_A got=%h exp=%h", obs(), sb[0]);
        end
        drive(0, 0, 32'h0, 1, 0);
        @(negedge clk);
        e = sb[0];
        checks++;
        if (obs() !== e || e.addr != 32'hB00) begin failures++; $display("FAIL bp_B got=%h exp=%h", obs(), e); end
        drive(1, 8, 32'hC00, 1, 0);
        @(negedge clk);
        e = sb[0];
        checks++;
        if (obs() !== e || e.addr != 32'hC00) begin failures++; $display("FAIL bp_C got=%h exp=%h", obs(), e); end
        drive(0, 0, 32'h0, 1, 0);
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", o_valid); end
    endtask

    task automatic test_flush();
        drive(1, 1, 32'h200, 0, 0);
        @(negedge clk);
        drive(1, 2, 32'h204, 0, 0);
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b0) begin failures++; $display("FAIL flush_full got=%b exp=0", o_ready); end
        drive(1, 3, 32'hDEAD, 1, 1);
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            failures++; $display("FAIL flush_empty valid=%b ready=%b exp valid=0 ready=1", o_valid, o_ready);
        end
        checks++;
        if (obs() !== '0) begin failures++; $display("FAIL flush_head got=%h exp=0", obs()); end
        drive(1, 10, 32'h300, 0, 0);
        @(negedge clk);
        checks++;
        if (obs() !== sb[0]) begin failures++; $display("FAIL flush_next got=%h exp=%h", obs(), sb[0]); end
        drive(1, 4, 32'hBEEF, 0, 1);
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL flush_drop got=%b exp=0", o_valid); end
        drive(0, 0, 32'h0, 0, 0);
    endtask

    task automatic test_decode();
        for (int k = 0; k < NTBL; k++) begin
            drive(1, k, 32'h1000 + 32'(k * 4), 1, 0);
            @(negedge clk);
            checks++;
            if (obs() !== sb[0]) begin
                failures++; $display("FAIL decode_%0d got=%h exp=%h", k, obs(), sb[0]);
            end
        end
        drive(0, 0, 32'h0, 1, 0);
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        drive(1, 11, 32'h400, 0, 0);
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b1) begin failures++; $display("FAIL areset_pre got=%b exp=1", o_valid); end
        drive(0, 0, 32'h0, 0, 0);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
            failures++; $display("FAIL areset_now valid=%b ready=%b exp 0 0", o_valid, o_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            failures++; $display("FAIL areset_post ready=%b valid=%b exp 1 0", o_ready, o_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            checks++;
            if (o_valid !== (sb.size() != 0) || o_ready !== (sb.size() < DEPTH)) begin
                failures++;
                $display("FAIL b2b_flags cyc=%0d valid=%b ready=%b exp_count=%0d", c, o_valid, o_ready, sb.size());
            end
            if (sb.size() != 0) begin
                checks++;
                if (obs() !== sb[0]) begin
                    failures++; $display("FAIL b2b_head cyc=%0d got=%h exp=%h", c, obs(), sb[0]);
                end
            end
            drive(($urandom % 4) != 0, int'($urandom_range(NTBL - 1)), $urandom,
                  ($urandom % 3) != 0, ($urandom % 20) == 0);
            @(negedge clk);
        end
        drive(0, 0, 32'h0, 1, 0);
        repeat (DEPTH + 1) @(negedge clk);
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", o_valid); end
    endtask

    initial begin
        init_table();
        test_reset();
        test_addi();
        test_backpressure();
        test_flush();
        test_decode();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
